// File: rtl/led_status_arbiter.sv
// Fixed-priority LED scheduler: three requesters share five LEDs, each grant
// shows a latched (optionally blinking) pattern for a fixed number of ticks.
module led_status_arbiter #(
    parameter int unsigned TICK_DIV   = 1200000,
    parameter int unsigned HOLD_TICKS = 5,
    parameter int unsigned HB_TICKS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [14:0] req_mask,
    input  logic [2:0]  req_blink,
    output logic [2:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        LED1,
    output logic        LED2,
    output logic        LED3,
    output logic        LED4,
    output logic        LED5
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned BW = $clog2(HB_TICKS + 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_d;
    logic [PW-1:0] pcnt, pcnt_d;
    logic [HW-1:0] hold, hold_d;
    logic [BW-1:0] hbcnt, hbcnt_d;
    logic          hb, hb_d;
    logic          phase, phase_d;
    logic [4:0]    mask, mask_d;
    logic          blink, blink_d;
    logic [2:0]    ack_d;
    logic [1:0]    owner_d;
    logic          busy_d;
    logic [4:0]    led, led_d;

    logic          tick;
    logic          expire;
    logic          preempt;
    logic          grant;
    logic [1:0]    win;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            hold  <= '0;
            hbcnt <= '0;
            hb    <= 1'b0;
            phase <= 1'b0;
            mask  <= '0;
            blink <= 1'b0;
            ack   <= '0;
            owner <= 2'b11;
            busy  <= 1'b0;
            led   <= '0;
        end else begin
            state <= state_d;
            pcnt  <= pcnt_d;
            hold  <= hold_d;
            hbcnt <= hbcnt_d;
            hb    <= hb_d;
            phase <= phase_d;
            mask  <= mask_d;
            blink <= blink_d;
            ack   <= ack_d;
            owner <= owner_d;
            busy  <= busy_d;
            led   <= led_d;
        end
    end

    // Next-state, grant arbitration and LED pattern
    always_comb begin
        state_d = state;
        pcnt_d  = pcnt;
        hold_d  = hold;
        hbcnt_d = hbcnt;
        hb_d    = hb;
        phase_d = phase;
        mask_d  = mask;
        blink_d = blink;
        ack_d   = 3'b000;
        owner_d = owner;
        busy_d  = 1'b0;
        led_d   = '0;
        grant   = 1'b0;

        tick   = (pcnt == PW'(TICK_DIV - 1));
        expire = tick && (hold == HW'(1));
        pcnt_d = tick ? '0 : pcnt + PW'(1);

        if (req[2])      win = 2'd2;
        else if (req[1]) win = 2'd1;
        else             win = 2'd0;

        case (owner)
            2'd0:    preempt = |req[2:1];
            2'd1:    preempt = req[2];
            default: preempt = 1'b0;
        endcase

        case (state)
            IDLE: begin
                if (|req) begin
                    grant = 1'b1;
                end else if (tick) begin
                    if (hbcnt == BW'(HB_TICKS - 1)) begin
                        hbcnt_d = '0;
                        hb_d    = ~hb;
                    end else begin
                        hbcnt_d = hbcnt + BW'(1);
                    end
                end
            end
            SHOW: begin
                if (preempt || (expire && (|req))) begin
                    grant = 1'b1;
                end else if (expire) begin
                    state_d = IDLE;
                    owner_d = 2'b11;
                    hbcnt_d = '0;
                end else if (tick) begin
                    hold_d  = hold - HW'(1);
                    phase_d = ~phase;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d = SHOW;
            ack_d   = 3'b001 << win;
            owner_d = win;
            blink_d = req_blink[win];
            hold_d  = HW'(HOLD_TICKS);
            phase_d = 1'b1;
            pcnt_d  = '0;
            case (win)
                2'd2:    mask_d = req_mask[14:10];
                2'd1:    mask_d = req_mask[9:5];
                default: mask_d = req_mask[4:0];
            endcase
        end

        busy_d = (state_d == SHOW);
        if (state_d == SHOW)
            led_d = blink_d ? (mask_d & {5{phase_d}}) : mask_d;
        else
            led_d = {hb_d, 4'b0000};
    end

    assign LED1 = led[0];
    assign LED2 = led[1];
    assign LED3 = led[2];
    assign LED4 = led[3];
    assign LED5 = led[4];

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with TICK_DIV=4, HOLD_TICKS=3, HB_TICKS=2.
module tb_led_status_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [14:0] req_mask;
    logic [2:0]  req_blink;
    logic [2:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic        LED1, LED2, LED3, LED4, LED5;
    logic [4:0]  leds;

    int checks = 0;
    int errors = 0;

    assign leds = {LED5, LED4, LED3, LED2, LED1};

    led_status_arbiter #(
        .TICK_DIV  (4),
        .HOLD_TICKS(3),
        .HB_TICKS  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_mask (req_mask),
        .req_blink(req_blink),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy),
        .LED1     (LED1),
        .LED2     (LED2),
        .LED3     (LED3),
        .LED4     (LED4),
        .LED5     (LED5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] r, input logic [14:0] m, input logic [2:0] b);
        req       = r;
        req_mask  = m;
        req_blink = b;
    endtask

    initial begin
        logic       exp_hb;
        logic [4:0] exp_led;

        rst = 1'b1;
        set_req(3'b000, 15'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_leds", leds, 5'b00000);
        chk("rst_owner", owner, 2'b11);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 3'b000);
        rst = 1'b0;

        // Idle heartbeat: LED5 toggles every 8 cycles from release
        for (int i = 1; i <= 24; i++) begin
            step();
            exp_hb = ((i / 8) % 2) == 1;
            chk("hb_leds", leds, {exp_hb, 4'b0000});
            chk("hb_owner", owner, 2'b11);
        end

        // Asynchronous reset mid-cycle while LED5 is on
        #3 rst = 1'b1;
        #1;
        chk("arst_leds", leds, 5'b00000);
        chk("arst_owner", owner, 2'b11);
        chk("arst_busy", busy, 1'b0);
        #1 rst = 1'b0;

        // Single grant, 12-cycle display
        set_req(3'b001, 15'b00000_00000_00101, 3'b000);
        step();
        chk("s2_ack", ack, 3'b001);
        chk("s2_owner", owner, 2'd0);
        chk("s2_busy", busy, 1'b1);
        chk("s2_leds", leds, 5'b00101);
        req = 3'b000;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("s2_hold_leds", leds, 5'b00101);
            chk("s2_hold_ack", ack, 3'b000);
            chk("s2_hold_busy", busy, 1'b1);
        end
        step();
        chk("s2_end_busy", busy, 1'b0);
        chk("s2_end_owner", owner, 2'b11);
        chk("s2_end_leds", leds, 5'b00000);

        // Simultaneous requests: high first, low at expiry with no gap
        set_req(3'b101, 15'b11000_00000_00011, 3'b000);
        step();
        chk("s3_ack2", ack, 3'b100);
        chk("s3_owner2", owner, 2'd2);
        chk("s3_leds2", leds, 5'b11000);
        req = 3'b001;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("s3_hold_ack", ack, 3'b000);
            chk("s3_hold_owner", owner, 2'd2);
            chk("s3_hold_busy", busy, 1'b1);
        end
        step();
        chk("s3_ack0", ack, 3'b001);
        chk("s3_owner0", owner, 2'd0);
        chk("s3_busy0", busy, 1'b1);
        chk("s3_leds0", leds, 5'b00011);
        req = 3'b000;
        repeat (11) step();
        step();
        chk("s3_end_busy", busy, 1'b0);
        chk("s3_end_owner", owner, 2'b11);

        // Preemption of requester 1 by requester 2; requester 0 waits for expiry
        set_req(3'b010, 15'b10001_01010_00001, 3'b000);
        step();
        chk("s4_ack1", ack, 3'b010);
        chk("s4_owner1", owner, 2'd1);
        chk("s4_leds1", leds, 5'b01010);
        req = 3'b000;
        repeat (4) step();
        chk("s4_pre_owner", owner, 2'd1);
        req = 3'b100;
        step();
        chk("s4_ack2", ack, 3'b100);
        chk("s4_owner2", owner, 2'd2);
        chk("s4_leds2", leds, 5'b10001);
        req = 3'b000;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 2) req = 3'b001;
            chk("s4_hold_owner", owner, 2'd2);
            chk("s4_hold_leds", leds, 5'b10001);
            chk("s4_hold_ack", ack, 3'b000);
        end
        step();
        chk("s4_ack0", ack, 3'b001);
        chk("s4_owner0", owner, 2'd0);
        chk("s4_leds0", leds, 5'b00001);
        req = 3'b000;
        repeat (11) step();
        step();
        chk("s4_end_busy", busy, 1'b0);

        // Blink: on 4, off 4, on 4, then idle
        set_req(3'b001, 15'b00000_00000_11111, 3'b001);
        step();
        chk("s5_leds_first", leds, 5'b11111);
        req = 3'b000;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_led = (((i / 4) % 2) == 0) ? 5'b11111 : 5'b00000;
            chk("s5_blink", leds, exp_led);
        end
        step();
        chk("s5_end_busy", busy, 1'b0);
        chk("s5_end_leds", leds, 5'b00000);

        // Reset mid-show, then a fresh grant
        set_req(3'b001, 15'b00000_00000_00101, 3'b000);
        step();
        chk("s6_busy", busy, 1'b1);
        req = 3'b000;
        repeat (3) step();
        #3 rst = 1'b1;
        #1;
        chk("s6_rst_leds", leds, 5'b00000);
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_owner", owner, 2'b11);
        chk("s6_rst_ack", ack, 3'b000);
        #1 rst = 1'b0;
        req = 3'b001;
        step();
        chk("s6_ack", ack, 3'b001);
        chk("s6_leds", leds, 5'b00101);
        chk("s6_busy2", busy, 1'b1);
        req = 3'b000;
        step();
        chk("s6_ack_drop", ack, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_arbiter.md
# led_status_arbiter

Fixed-priority scheduler that shares the board's five LEDs among three status requesters (e.g. SD/SPI error, transfer activity, init status) and shows an idle heartbeat when no one owns them. Each grant latches a 5-bit LED mask, optionally blinks it, and holds the display for a fixed number of prescaled ticks. It sits between the SD-card control logic and the LED pins, replacing direct LED drive.

## Interface
- `TICK_DIV`, 1200000: clk cycles per tick (100 ms at 12 MHz); must be ≥2.
- `HOLD_TICKS`, 5: ticks a granted pattern is displayed; must be ≥1.
- `HB_TICKS`, 5: ticks per heartbeat half-period in idle; must be ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  request level per requester; bit 2 has the highest priority and bit 0 the lowest.
- `req_mask`  in  15  LED pattern per requester; `[5i+4:5i]` belongs to requester i, and bit 0 of each field maps to `LED1`.
- `req_blink`  in  3  blink enable per requester.
- `ack`  out  3  one-cycle grant pulse, one-hot.
- `owner`  out  2  current owner index; 2'b11 means none.
- `busy`  out  1  high while a pattern is displayed.
- `LED1`..`LED5`  out  1 each  registered LED drives.

## Operation
- Prescaler `pcnt` counts from 0 to TICK_DIV-1 and wraps. `tick` is an internal pulse that fires when `pcnt == TICK_DIV-1`. The prescaler is forced to 0 on every grant.
- States:
  - IDLE (`busy=0`, `owner=3`)
  - SHOW (`busy=1`, `owner` = latched index)
- A grant is evaluated in these cases:
  - IDLE: on any `req` bit.
  - SHOW: on a `req` bit of higher priority than `owner` (preemption), or on hold expiry (see below).
  - The winner is the highest set bit. Lower-priority or same-owner requests in SHOW are ignored until expiry.
- On a grant to index i, the block registers:
  - `ack[i]`=1 for one cycle
  - `owner`=i
  - latched mask = `req_mask` field i, latched blink = `req_blink[i]`
  - `hold`=HOLD_TICKS, `phase`=1, `pcnt`=0
  - state=SHOW
- SHOW, on each `tick`: `hold` decrements and `phase` toggles.
- Expiry occurs when `tick` fires with `hold==1`:
  - If any `req` is set in that cycle, the highest one is granted directly (SHOW→SHOW) and the expiring owner's request is included in the evaluation.
  - Otherwise the next state is IDLE.
- LED drive in SHOW: `{LED5..LED1}` = mask if blink=0; mask & {5{phase}} if blink=1.
- LED drive in IDLE: `LED1`..`LED4`=0 and `LED5`=`hb`. `hb` toggles every HB_TICKS ticks via the `hbcnt` counter, which is frozen in SHOW and cleared to 0 on entry to IDLE; `hb` keeps its value.
- Requester contract: `req` is a level signal and must drop in the cycle after its `ack`. A `req` still high when evaluated later counts as a new request and is re-granted.
- Reset (async, any state, mid-display included): IDLE, all LEDs 0, `ack`=0, `busy`=0, `owner`=3, `pcnt`=`hold`=`hbcnt`=0, `hb`=0, `phase`=0.

## Timing
- Grant latency: `req` sampled high at edge N gives `ack`, `owner`, `busy` and the LED pattern all valid after edge N+1.
- Display length: exactly HOLD_TICKS×TICK_DIV cycles from grant to the first cycle of IDLE (or of the next grant).
- Blink: on for TICK_DIV cycles, then off for TICK_DIV cycles, starting in the on phase.
- Heartbeat: `LED5` half-period in IDLE is HB_TICKS×TICK_DIV cycles, measured from IDLE entry.
- `ack` is never high for two consecutive cycles to the same index unless a new grant occurs.
- Prescaler width: `$clog2(TICK_DIV)`; the `hold` and `hbcnt` widths cover their parameters. There is no overflow path.

## Test plan
All scenarios use TICK_DIV=4, HOLD_TICKS=3, HB_TICKS=2.
1. **Reset/idle:** assert `rst` asynchronously mid-cycle → all LEDs 0, `owner`=3 immediately. After release with no `req` → `LED5` rises after 8 cycles and toggles every 8 cycles; `LED1`..`LED4` stay 0.
2. **Single grant:** `req[0]`=1 for one cycle with mask 5'b00101 and blink=0 → `ack`=3'b001 one cycle later; `LED1`=`LED3`=1 for exactly 12 cycles; then IDLE and `busy`=0.
3. **Simultaneous requests:** `req`=3'b101 held until each is acked → `ack[2]` first; `ack[0]` in the expiry cycle, 12 cycles later, with no IDLE gap.
4. **Preemption:** `req[1]` granted; 5 cycles later `req[2]` → `ack[2]` next cycle and `owner`=2 with its mask shown for a full 12 cycles. A `req[0]` raised during the display is granted only at expiry.
5. **Blink:** mask 5'b11111 with blink=1 → LEDs all on for 4 cycles, off for 4, on for 4, then IDLE.
6. **Reset mid-show:** `rst` pulse during scenario 2 → LEDs 0 and `busy`=0 at once; a new `req` after release is granted with 1-cycle latency.
